// File: rtl/flow_distributor_nway.sv
// flow_distributor_nway: round-robin demultiplexer of a serial block stream
// into N_FLOWS parallel flows (block k -> flow k mod N_FLOWS). Supports
// grouped (double-buffered) or per-flow strobe output, sync-driven group
// realignment, and a misalignment pulse when a partial group is dropped.
module flow_distributor_nway #(
  parameter int BITS_BLOCK = 257,
  parameter int N_FLOWS    = 2,
  parameter int GROUPED    = 1,
  parameter int IDX_W      = $clog2(N_FLOWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_valid,
  input  logic                          i_sync,
  input  logic [BITS_BLOCK-1:0]         input_blocks,
  output logic [N_FLOWS*BITS_BLOCK-1:0] flow_data,
  output logic [N_FLOWS-1:0]            flow_valid,
  output logic                          valid,
  output logic [IDX_W-1:0]              next_flow,
  output logic                          err_misalign
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(N_FLOWS - 1);

  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [IDX_W-1:0]              slot;
  logic                          last_acc;
  logic                          err_q, err_d;
  logic [N_FLOWS*BITS_BLOCK-1:0] flow_data_q;
  logic [N_FLOWS-1:0]            flow_valid_q;
  logic                          valid_q;

  // Slot selection and next index: sync forces the current block into slot 0.
  always_comb begin
    slot     = i_sync ? '0 : idx_q;
    last_acc = i_valid && (slot == LAST_SLOT);
    err_d    = i_sync && (idx_q != '0);
    idx_d    = idx_q;
    if (i_sync) begin
      idx_d = i_valid ? IDX_W'(1) : '0;
    end else if (i_valid) begin
      idx_d = (idx_q == LAST_SLOT) ? '0 : idx_q + IDX_W'(1);
    end
  end

  // Index counter and misalignment pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      err_q <= err_d;
    end
  end

  generate
    if (GROUPED != 0) begin : g_grouped
      // Only slots 0..N-2 need collecting; the last block goes straight
      // into the output register together with the shadow contents.
      logic [N_FLOWS-2:0][BITS_BLOCK-1:0] shadow_q;

      // Collect partial group and publish a complete group in one edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          shadow_q     <= '0;
          flow_data_q  <= '0;
          flow_valid_q <= '0;
          valid_q      <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < N_FLOWS - 1; k++) begin
            if (i_valid && (slot == IDX_W'(k))) begin
              shadow_q[k] <= input_blocks;
            end
          end
          if (last_acc) begin
            flow_data_q <= {input_blocks, shadow_q};
          end
          flow_valid_q <= {N_FLOWS{last_acc}};
          valid_q      <= last_acc;
        end
      end
    end else begin : g_streamed
      // Write each accepted block directly into its output slot.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          flow_data_q  <= '0;
          flow_valid_q <= '0;
          valid_q      <= 1'b0;
        end else begin
          for (int unsigned k = 0; k < N_FLOWS; k++) begin
            if (i_valid && (slot == IDX_W'(k))) begin
              flow_data_q[k*BITS_BLOCK +: BITS_BLOCK] <= input_blocks;
            end
            flow_valid_q[k] <= i_valid && (slot == IDX_W'(k));
          end
          valid_q <= last_acc;
        end
      end
    end
  endgenerate

  assign flow_data    = flow_data_q;
  assign flow_valid   = flow_valid_q;
  assign valid        = valid_q;
  assign next_flow    = idx_q;
  assign err_misalign = err_q;

endmodule

// File: tb/tb_flow_distributor_nway.sv
// Bench for flow_distributor_nway: a grouped 4-flow instance and a streamed
// 3-flow instance share one randomized input stream. A queue-based model
// predicts group completions, per-flow writes and misalignment pulses; a
// monitor compares each cycle.
module tb_flow_distributor_nway;

  localparam int BW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_valid;
  logic          i_sync;
  logic [BW-1:0] blk;

  logic [4*BW-1:0] fd4;
  logic [3:0]      fv4;
  logic            v4;
  logic [1:0]      nf4;
  logic            e4;

  logic [3*BW-1:0] fd3;
  logic [2:0]      fv3;
  logic            v3;
  logic [1:0]      nf3;
  logic            e3;

  always #5 clk = ~clk;

  flow_distributor_nway #(.BITS_BLOCK(BW), .N_FLOWS(4), .GROUPED(1)) dut4 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sync(i_sync),
    .input_blocks(blk), .flow_data(fd4), .flow_valid(fv4), .valid(v4),
    .next_flow(nf4), .err_misalign(e4)
  );

  flow_distributor_nway #(.BITS_BLOCK(BW), .N_FLOWS(3), .GROUPED(0)) dut3 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_sync(i_sync),
    .input_blocks(blk), .flow_data(fd3), .flow_valid(fv3), .valid(v3),
    .next_flow(nf3), .err_misalign(e3)
  );

  typedef struct {
    int unsigned     cyc;
    logic [4*BW-1:0] data;
  } grp_t;

  typedef struct {
    int unsigned   cyc;
    int unsigned   slot;
    logic [BW-1:0] d;
  } wr_t;

  int unsigned checks = 0;
  int unsigned passes = 0;
  int unsigned cyc    = 0;
  bit          in_reset;

  logic [BW-1:0] l4[$];
  logic [BW-1:0] l3[$];
  grp_t          gq[$];
  wr_t           sq[$];
  int unsigned   e4q[$];
  int unsigned   e3q[$];
  logic [4*BW-1:0] hold4;
  logic [3*BW-1:0] hold3;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic reset_check();
    chk("rst_fd4", fd4, 0);  chk("rst_fv4", fv4, 0);  chk("rst_v4", v4, 0);
    chk("rst_nf4", nf4, 0);  chk("rst_e4", e4, 0);
    chk("rst_fd3", fd3, 0);  chk("rst_fv3", fv3, 0);  chk("rst_v3", v3, 0);
    chk("rst_nf3", nf3, 0);  chk("rst_e3", e3, 0);
  endtask

  task automatic flush_model();
    l4.delete(); l3.delete(); gq.delete(); sq.delete(); e4q.delete(); e3q.delete();
    hold4 = '0;
    hold3 = '0;
  endtask

  // Apply one cycle of input and record what the model expects one cycle later.
  task automatic drive(input bit v, input bit s, input logic [BW-1:0] d);
    grp_t g;
    wr_t  w;
    @(negedge clk);
    i_valid = v;
    i_sync  = s;
    blk     = d;
    if (s) begin
      if (l4.size() != 0) e4q.push_back(cyc + 1);
      if (l3.size() != 0) e3q.push_back(cyc + 1);
      l4.delete();
      l3.delete();
    end
    if (v) begin
      l4.push_back(d);
      if (l4.size() == 4) begin
        g.cyc  = cyc + 1;
        g.data = '0;
        for (int k = 0; k < 4; k++) g.data[k*BW +: BW] = l4[k];
        gq.push_back(g);
        l4.delete();
      end
      w.cyc  = cyc + 1;
      w.slot = l3.size();
      w.d    = d;
      sq.push_back(w);
      l3.push_back(d);
      if (l3.size() == 3) l3.delete();
    end
  endtask

  // Monitor: compare DUT outputs against the model one step after each edge.
  initial begin : monitor
    grp_t g;
    wr_t  w;
    bit   exp_e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!in_reset) begin
        chk("next_flow4", nf4, l4.size());
        chk("next_flow3", nf3, l3.size());

        if (gq.size() != 0 && gq[0].cyc == cyc) begin
          g = gq.pop_front();
          hold4 = g.data;
          chk("valid4", v4, 1);
          chk("flow_valid4", fv4, 4'hf);
        end else begin
          chk("valid4", v4, 0);
          chk("flow_valid4", fv4, 0);
        end
        chk("flow_data4", fd4, hold4);

        exp_e = (e4q.size() != 0 && e4q[0] == cyc);
        if (exp_e) void'(e4q.pop_front());
        chk("err4", e4, exp_e);

        if (sq.size() != 0 && sq[0].cyc == cyc) begin
          w = sq.pop_front();
          hold3[w.slot*BW +: BW] = w.d;
          chk("flow_valid3", fv3, 1 << w.slot);
          chk("valid3", v3, (w.slot == 2));
        end else begin
          chk("flow_valid3", fv3, 0);
          chk("valid3", v3, 0);
        end
        chk("flow_data3", fd3, hold3);

        exp_e = (e3q.size() != 0 && e3q[0] == cyc);
        if (exp_e) void'(e3q.pop_front());
        chk("err3", e3, exp_e);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    in_reset = 1'b1;
    i_valid  = 1'b0;
    i_sync   = 1'b0;
    blk      = '0;
    flush_model();
    #3;
    reset_check();
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    in_reset = 1'b0;

    // Back-to-back blocks 0..11: three full groups of four.
    for (int k = 0; k < 12; k++) drive(1'b1, 1'b0, BW'(k));
    repeat (3) drive(1'b0, 1'b0, '0);

    // Streamed spacing with idle gaps.
    for (int k = 5; k < 8; k++) begin
      drive(1'b1, 1'b0, BW'(k));
      repeat (2) drive(1'b0, 1'b0, '0);
    end

    // Realign mid-group with a block, then complete the new group.
    drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 24'h0000a1);
    drive(1'b1, 1'b0, 24'h0000a2);
    drive(1'b1, 1'b1, 24'h00cafe);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, BW'(24'hb0 + k));
    drive(1'b0, 1'b0, '0);

    // Sync alone at index 0 (no error), then at index 3 (error).
    drive(1'b0, 1'b1, '0);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, BW'(24'hc0 + k));
    drive(1'b0, 1'b1, '0);
    repeat (2) drive(1'b0, 1'b0, '0);

    // Randomized traffic with occasional syncs.
    for (int n = 0; n < 1500; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 15) == 0), BW'($urandom));
    end

    // Asynchronous reset in the middle of a group.
    drive(1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 24'h0d0d01);
    drive(1'b1, 1'b0, 24'h0d0d02);
    drive(1'b0, 1'b0, '0);
    #2;
    rst      = 1'b1;
    in_reset = 1'b1;
    #1;
    reset_check();
    flush_model();
    @(negedge clk);
    rst      = 1'b0;
    in_reset = 1'b0;
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, BW'(24'he0 + k));
    repeat (3) drive(1'b0, 1'b0, '0);
    #2;
    chk("drain", gq.size() + sq.size() + e4q.size() + e3q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
